// File: rtl/sha256_block_sequencer_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and round helper functions
// for the iterative block sequencer and its single-round compression stage.
package sha256_block_sequencer_pkg;

  typedef logic [31:0] uint32_t;

  // Element 0 sits in the most significant bits, so W0 lands at [511:480].
  typedef logic [0:15][31:0] block_words_t;

  typedef struct packed {
    uint32_t a;
    uint32_t b;
    uint32_t c;
    uint32_t d;
    uint32_t e;
    uint32_t f;
    uint32_t g;
    uint32_t h;
  } working_vars_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_ADD,
    ST_HOLD
  } seq_state_t;

  localparam uint32_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam working_vars_t IV = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic block_words_t to_words(input logic [511:0] v);
    return block_words_t'(v);
  endfunction

  function automatic uint32_t rotr(input uint32_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic uint32_t big_sigma0(input uint32_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic uint32_t big_sigma1(input uint32_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic uint32_t small_sigma0(input uint32_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic uint32_t small_sigma1(input uint32_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic working_vars_t add_vars(input working_vars_t x, input working_vars_t y);
    working_vars_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_block_sequencer_if.sv
// Block-in / digest-out handshake bundle between the miner front end, the sequencer
// and the nonce/target compare stage.
interface sha256_block_sequencer_if;
  logic         blockValid;
  logic         blockReady;
  logic [511:0] blockData;
  logic         blockFirst;
  logic         digestValid;
  logic         digestReady;
  logic [255:0] digest;
  logic         busy;

  modport master (
    output blockValid, blockData, blockFirst, digestReady,
    input  blockReady, digestValid, digest, busy
  );

  modport slave (
    input  blockValid, blockData, blockFirst, digestReady,
    output blockReady, digestValid, digest, busy
  );
endinterface

// File: rtl/sha256_block_sequencer_round.sv
// Single SHA-256 round with a rolling 16-word message schedule; outputs are registered
// and have no reset, the sequencer ignores them until round 0 of a block is issued.
module sha256_block_sequencer_round
  import sha256_block_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          en,
  input  uint32_t       k,
  input  block_words_t  w_in,
  input  working_vars_t vars_in,
  output block_words_t  w_out,
  output working_vars_t vars_out
);

  block_words_t  w_d, w_q;
  working_vars_t vars_d, vars_q;
  uint32_t       t1, t2, ch, maj;

  always_comb begin
    ch  = (vars_in.e & vars_in.f) ^ (~vars_in.e & vars_in.g);
    maj = (vars_in.a & vars_in.b) ^ (vars_in.a & vars_in.c) ^ (vars_in.b & vars_in.c);
    t1  = vars_in.h + big_sigma1(vars_in.e) + ch + k + w_in[0];
    t2  = big_sigma0(vars_in.a) + maj;

    vars_d = '{a: t1 + t2, b: vars_in.a, c: vars_in.b, d: vars_in.c,
               e: vars_in.d + t1, f: vars_in.e, g: vars_in.f, h: vars_in.g};

    // Window slides by one word; the new tail is W[n+16] from W[n], W[n+1], W[n+9], W[n+14].
    w_d = {w_in[1:15],
           small_sigma1(w_in[14]) + w_in[9] + small_sigma0(w_in[1]) + w_in[0]};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      w_q    <= w_d;
      vars_q <= vars_d;
    end
  end

  assign w_out    = w_q;
  assign vars_out = vars_q;

endmodule

// File: rtl/sha256_block_sequencer.sv
// Iterative SHA-256 block engine: accepts a padded 512-bit block, runs ROUNDS rounds through
// one round stage, folds the result into the chaining state and holds the digest until taken.
module sha256_block_sequencer
  import sha256_block_sequencer_pkg::*;
#(
  parameter int unsigned ROUNDS = 64,
  parameter bit          USE_IV = 1'b1
) (
  input logic                     clk,
  input logic                     rstN,
  sha256_block_sequencer_if.slave bus
);

  localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 1);

  seq_state_t    state_d, state_q;
  logic [5:0]    cnt_d, cnt_q;
  working_vars_t h_d, h_q;
  block_words_t  blk_d, blk_q;

  uint32_t       round_k;
  block_words_t  round_w_in, round_w_out;
  working_vars_t round_vars_in, round_vars_out;
  logic          round_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    blk_d   = blk_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.blockValid) begin
          blk_d = to_words(bus.blockData);
          if (bus.blockFirst && USE_IV) begin
            h_d = IV;
          end
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_ADD;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_ADD: begin
        h_d     = add_vars(h_q, round_vars_out);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.digestReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      h_q     <= IV;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      blk_q   <= blk_d;
    end
  end

  // Round 0 starts from the latched block and H; later rounds loop the stage back on itself.
  always_comb begin
    round_k       = K[cnt_q];
    round_en      = (state_q == ST_RUN);
    round_w_in    = (cnt_q == '0) ? blk_q : round_w_out;
    round_vars_in = (cnt_q == '0) ? h_q   : round_vars_out;
  end

  sha256_block_sequencer_round u_round (
    .clk      (clk),
    .en       (round_en),
    .k        (round_k),
    .w_in     (round_w_in),
    .vars_in  (round_vars_in),
    .w_out    (round_w_out),
    .vars_out (round_vars_out)
  );

  always_comb begin
    bus.blockReady  = rstN && (state_q == ST_IDLE);
    bus.digestValid = (state_q == ST_HOLD);
    bus.digest      = (state_q == ST_HOLD) ? h_q : '0;
    bus.busy        = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed and randomized checks of sha256_block_sequencer against an array-based
// SHA-256 compression model and published digests.
module tb_sha256_block_sequencer;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_M = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO1_BLK  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2_BLK  = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   acc = 0;
  logic [255:0] model_h = IV_M;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_block_sequencer_if bus ();

  sha256_block_sequencer #(.ROUNDS(64), .USE_IV(1'b1)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic model_next(input logic [511:0] blk, input logic first, output logic [255:0] e);
    if (first) model_h = IV_M;
    model_h = compress(model_h, blk);
    e = model_h;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s observed=timeout expected=event within bound", tag);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = $urandom();
    return b;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [511:0] blk, input logic first);
    bus.blockValid = 1'b1;
    bus.blockData  = blk;
    bus.blockFirst = first;
    for (int i = 0; i < 300; i++) begin
      if (bus.blockReady === 1'b1) begin
        acc = cyc + 1;
        @(negedge clk);
        bus.blockValid = 1'b0;
        bus.blockData  = rand_block();
        bus.blockFirst = ~first;
        return;
      end
      @(negedge clk);
    end
    timeout_fail("send");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300; i++) begin
      if (bus.digestValid === 1'b1) return;
      @(negedge clk);
    end
    timeout_fail("wait_valid");
  endtask

  task automatic get_digest(input int stall, output logic [255:0] d, output int lat);
    d   = '0;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.digestValid === 1'b1) begin
        lat = cyc - acc;
        d   = bus.digest;
        repeat (stall) @(negedge clk);
        bus.digestReady = 1'b1;
        @(negedge clk);
        bus.digestReady = 1'b0;
        return;
      end
      @(negedge clk);
    end
    timeout_fail("get_digest");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d, e;
    logic [511:0] r1, r2;
    int           lat, nacc, ndig;
    int           dig_t [$];

    bus.blockValid  = 1'b0;
    bus.blockData   = '0;
    bus.blockFirst  = 1'b0;
    bus.digestReady = 1'b0;
    #1 rstN = 1'b0;
    #11;
    check("rst_ready",  256'(bus.blockReady),  256'(0));
    check("rst_valid",  256'(bus.digestValid), 256'(0));
    check("rst_digest", bus.digest,            256'(0));
    check("rst_busy",   256'(bus.busy),        256'(0));
    @(negedge clk) rstN = 1'b1;
    #1 check("post_rst_ready", 256'(bus.blockReady), 256'(1));
    @(negedge clk);

    // "abc": digest and exact latency
    model_next(ABC_BLK, 1'b1, e);
    send(ABC_BLK, 1'b1);
    check("run_busy",  256'(bus.busy),       256'(1));
    check("run_ready", 256'(bus.blockReady), 256'(0));
    get_digest(0, d, lat);
    check("abc_digest",  d,         ABC_DIG);
    check("abc_latency", 256'(lat), 256'(65));
    check("idle_valid", 256'(bus.digestValid), 256'(0));
    check("idle_busy",  256'(bus.busy),        256'(0));
    check("idle_ready", 256'(bus.blockReady),  256'(1));

    // empty message
    model_next(EMPTY_BLK, 1'b1, e);
    send(EMPTY_BLK, 1'b1);
    get_digest(1, d, lat);
    check("empty_digest", d, EMPTY_DIG);

    // two-block message with chaining
    model_next(TWO1_BLK, 1'b1, e);
    send(TWO1_BLK, 1'b1);
    get_digest(0, d, lat);
    check("two_first_digest", d, e);
    model_next(TWO2_BLK, 1'b0, e);
    send(TWO2_BLK, 1'b0);
    get_digest(0, d, lat);
    check("two_final_digest", d, TWO_DIG);

    // stall in HOLD with a new block waiting
    r1 = rand_block();
    r2 = rand_block();
    model_next(r1, 1'b1, e);
    send(r1, 1'b1);
    wait_valid();
    bus.blockValid = 1'b1;
    bus.blockData  = r2;
    bus.blockFirst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("hold_digest", bus.digest, e);
      check("hold_flags", 256'({bus.digestValid, bus.blockReady, bus.busy}), 256'(3'b101));
      @(negedge clk);
    end
    bus.digestReady = 1'b1;
    @(negedge clk);
    bus.digestReady = 1'b0;
    check("release_ready", 256'(bus.blockReady),  256'(1));
    check("release_valid", 256'(bus.digestValid), 256'(0));
    acc = cyc + 1;
    @(negedge clk);
    bus.blockValid = 1'b0;
    check("next_accepted", 256'({bus.busy, bus.blockReady}), 256'(2'b10));
    model_next(r2, 1'b1, e);
    get_digest(2, d, lat);
    check("next_digest",  d,         e);
    check("next_latency", 256'(lat), 256'(65));

    // reset mid-run, then "abc" without blockFirst must restart from IV
    model_next(ABC_BLK, 1'b1, e);
    send(ABC_BLK, 1'b1);
    repeat (30) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    check("midrst_outputs", 256'({bus.blockReady, bus.digestValid, bus.busy}), 256'(0));
    check("midrst_digest",  bus.digest, 256'(0));
    model_h = IV_M;
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);
    model_next(ABC_BLK, 1'b0, e);
    send(ABC_BLK, 1'b0);
    get_digest(0, d, lat);
    check("midrst_abc_digest", d, ABC_DIG);

    // back-to-back with both handshakes held high
    nacc = 0;
    ndig = 0;
    bus.digestReady = 1'b1;
    bus.blockValid  = 1'b1;
    bus.blockData   = ABC_BLK;
    bus.blockFirst  = 1'b1;
    for (int i = 0; i < 400 && ndig < 4; i++) begin
      if (bus.digestValid === 1'b1) begin
        check("b2b_digest", bus.digest, ABC_DIG);
        dig_t.push_back(cyc);
        ndig++;
      end
      if (bus.blockValid && bus.blockReady === 1'b1) nacc++;
      @(negedge clk);
      if (nacc >= 4) bus.blockValid = 1'b0;
    end
    bus.digestReady = 1'b0;
    check("b2b_accepts", 256'(nacc), 256'(4));
    check("b2b_digests", 256'(ndig), 256'(4));
    for (int i = 1; i < dig_t.size(); i++)
      check("b2b_spacing", 256'(dig_t[i] - dig_t[i-1]), 256'(67));
    model_h = compress(IV_M, ABC_BLK);

    // random blocks and chaining against the model
    for (int i = 0; i < 6; i++) begin
      logic first;
      r1    = rand_block();
      first = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      model_next(r1, first, e);
      send(r1, first);
      get_digest(int'($urandom_range(0, 3)), d, lat);
      check("rand_digest",  d,         e);
      check("rand_latency", 256'(lat), 256'(65));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
